// File: rtl/expand_data.sv
// Lossless fixed-point widening of PARALLEL packed samples with sync-framed beat filtering.
// Define EXPAND_DATA_ERRCNT_EN to build the saturating framing-error counter on err_count.
module expand_data #(
  parameter int    DIN_WIDTH  = 9,
  parameter int    DIN_POINT  = 8,
  parameter int    DOUT_WIDTH = 18,
  parameter int    DOUT_POINT = 16,
  parameter string DATA_TYPE  = "signed",
  parameter int    PARALLEL   = 4,
  parameter int    FRAME_LEN  = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIN_WIDTH*PARALLEL-1:0]    din,
  input  logic                             din_valid,
  input  logic                             sync_in,
  output logic [DOUT_WIDTH*PARALLEL-1:0]   dout,
  output logic                             dout_valid,
  output logic                             sync_out,
  output logic                             frame_err,
  output logic [15:0]                      err_count
);

  localparam int PAD       = DOUT_POINT - DIN_POINT;
  localparam bit IS_SIGNED = (DATA_TYPE == "signed");
  localparam int CW        = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  if (DOUT_POINT < DIN_POINT || (DOUT_WIDTH - DOUT_POINT) < (DIN_WIDTH - DIN_POINT) ||
      FRAME_LEN < 2 || !(DATA_TYPE == "signed" || DATA_TYPE == "unsigned")) begin : g_param_check
    $error("expand_data: illegal parameter combination");
  end

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fwd, err;

  logic                          s1_valid_q, s1_sync_q;
  logic [DIN_WIDTH*PARALLEL-1:0] s1_data_q;
  logic                          frame_err_q;
  logic [DOUT_WIDTH*PARALLEL-1:0] exp_w;
  logic [DOUT_WIDTH*PARALLEL-1:0] dout_q;
  logic                          dout_valid_q, sync_out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fwd     = 1'b0;
    err     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        WAIT_SYNC: begin
          if (sync_in) begin
            fwd     = 1'b1;
            cnt_d   = CW'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync_in) begin
            // early sync resynchronises on this beat rather than dropping it
            fwd   = 1'b1;
            err   = (cnt_q != '0);
            cnt_d = CW'(1);
          end else if (cnt_q == '0) begin
            err     = 1'b1;
            state_d = WAIT_SYNC;
          end else begin
            fwd   = 1'b1;
            cnt_d = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + CW'(1);
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SYNC;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sync_q   <= 1'b0;
      s1_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= fwd;
      s1_sync_q   <= fwd & sync_in;
      frame_err_q <= err;
      if (fwd) s1_data_q <= din;
    end
  end

  for (genvar g = 0; g < PARALLEL; g++) begin : g_lane
    logic [DIN_WIDTH-1:0]  smp;
    logic [DOUT_WIDTH-1:0] ext;
    assign smp = s1_data_q[g*DIN_WIDTH +: DIN_WIDTH];
    always_comb begin
      ext = DOUT_WIDTH'(smp) << PAD;
      if (IS_SIGNED && smp[DIN_WIDTH-1]) ext = ext | ({DOUT_WIDTH{1'b1}} << (PAD + DIN_WIDTH));
    end
    assign exp_w[g*DOUT_WIDTH +: DOUT_WIDTH] = ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_out_q   <= 1'b0;
    end else begin
      dout_valid_q <= s1_valid_q;
      sync_out_q   <= s1_sync_q;
      if (s1_valid_q) dout_q <= exp_w;
    end
  end

`ifdef EXPAND_DATA_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (frame_err_q && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_out   = sync_out_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/expand_data.md
EXPAND_DATA -- requirements
Module: expand_data

Interface
REQ-001 The module SHALL have parameter DIN_WIDTH, default 9, narrow input sample width.
REQ-002 The module SHALL have parameter DIN_POINT, default 8, input fractional bits.
REQ-003 The module SHALL have parameter DOUT_WIDTH, default 18, expanded output sample width.
REQ-004 The module SHALL have parameter DOUT_POINT, default 16, output fractional bits.
REQ-005 The module SHALL have parameter DATA_TYPE, default "signed", "signed" or "unsigned" extension.
REQ-006 The module SHALL have parameter PARALLEL, default 4, samples per beat.
REQ-007 The module SHALL have parameter FRAME_LEN, default 64, valid beats per sync frame (>=2).
REQ-008 The module SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-010 The module SHALL have port din, input, DIN_WIDTH*PARALLEL, packed narrow samples, sample 0 in LSBs.
REQ-011 The module SHALL have port din_valid, input, 1, beat qualifier.
REQ-012 The module SHALL have port sync_in, input, 1, frame start marker, coincident with beat 0.
REQ-013 The module SHALL have port dout, output, DOUT_WIDTH*PARALLEL, packed expanded samples.
REQ-014 The module SHALL have port dout_valid, output, 1, expanded beat qualifier.
REQ-015 The module SHALL have port sync_out, output, 1, sync aligned to dout.
REQ-016 The module SHALL have port frame_err, output, 1, one-cycle pulse per framing violation.
REQ-017 The module SHALL have port err_count, output, 16, saturating framing-error count.

Function
REQ-018 Expansion SHALL be lossless: DIN_POINT zero-padded to DOUT_POINT in LSBs; integer part sign-extended ("signed") or zero-extended ("unsigned"); elaboration SHALL fail if DOUT_POINT<DIN_POINT or DOUT_WIDTH-DOUT_POINT<DIN_WIDTH-DIN_POINT.
REQ-019 Datapath latency SHALL be exactly 2 cycles from accepted din/din_valid/sync_in to dout/dout_valid/sync_out, in two register stages.
REQ-020 dout SHALL hold its last value when dout_valid is low.
REQ-021 Frame FSM SHALL have states WAIT_SYNC and RUN, with beat counter cnt in 0..FRAME_LEN-1.
REQ-022 In WAIT_SYNC, valid beats without sync_in SHALL be dropped (no dout_valid); sync_in&din_valid SHALL forward the beat, set cnt=1, enter RUN.
REQ-023 In RUN, each valid beat SHALL be forwarded and cnt SHALL increment, wrapping FRAME_LEN-1 -> 0.
REQ-024 In RUN, sync_in&din_valid with cnt=0 SHALL be a normal frame start (cnt=1).
REQ-025 In RUN, sync_in&din_valid with cnt!=0 (early sync) SHALL forward the beat, pulse frame_err, and resynchronise to cnt=1.
REQ-026 In RUN, din_valid without sync_in at cnt=0 (missing sync) SHALL drop the beat, pulse frame_err, enter WAIT_SYNC.
REQ-027 sync_in without din_valid SHALL be ignored in both states.
REQ-028 frame_err SHALL assert 1 cycle after the offending beat, for exactly 1 cycle.
REQ-029 err_count SHALL increment on each frame_err pulse, saturating at 0xFFFF.

Reset
REQ-030 rst_n low SHALL asynchronously clear dout, dout_valid, sync_out, frame_err, err_count, cnt and pipeline valids, and force WAIT_SYNC.
REQ-031 Reset mid-frame SHALL discard in-flight beats; after release the first forwarded beat SHALL require sync_in.

Configuration
REQ-032 With macro EXPAND_DATA_ERRCNT_EN defined, err_count SHALL be the saturating counter of REQ-029; undefined, err_count SHALL be constant 0 and its counter SHALL not be synthesised; frame_err is unaffected.

Verification
REQ-033 Signed defaults: sync+valid, sample 0x1FF -> 2 cycles later sync_out=1, dout_valid=1, sample 0x3FF00; sample 0x100 -> 0x30000; 0x0FF -> 0x0FF00.
REQ-034 DATA_TYPE="unsigned": sample 0x1FF -> 0x1FF00; 0x100 -> 0x10000.
REQ-035 64 valid beats with sync on beat 0, then next sync -> 128 forwarded beats, frame_err never asserted.
REQ-036 Sync on beat 10 of a frame -> beat forwarded, frame_err pulse 1 cycle, err_count=1, next frame starts from that beat.
REQ-037 Beat 64 without sync -> dropped, frame_err pulse, later beats dropped until sync+valid; err_count saturates at 0xFFFF after 65536+ errors (0 without EXPAND_DATA_ERRCNT_EN).
REQ-038 rst_n low at beat 30 with valid in flight -> all outputs 0 asynchronously; post-release unsynced beats dropped.
